// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity, 1-2 stop bits
// and a show-ahead receive FIFO (valid/ready pop, sticky overrun).
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 50,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  busy
);
    localparam int MID  = (CLK_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int BW   = $clog2(DATA_WIDTH);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int EW   = DATA_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_d;
    logic                  sync1, s;
    logic [CW-1:0]         cnt;
    logic                  v0, v1, maj, vote_done;
    logic [BW-1:0]         bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err, frm_err, armed;
    logic                  push, push_ferr, xor_all, par_bad;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [NW-1:0]         count;
    logic                  full, do_pop, accept;
    logic [EW-1:0]         head;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= rx_in;
            s     <= sync1;
        end
    end

    assign maj       = (v0 & v1) | (v0 & s) | (v1 & s);
    assign vote_done = (state != IDLE) && (cnt == CW'(MID + 1));
    assign push_ferr = frm_err | ~maj;
    assign xor_all   = (^shreg) ^ maj;
    assign par_bad   = (PARITY_MODE == 2) ? ~xor_all : xor_all;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        push    = 1'b0;
        case (state)
            IDLE:   if (armed && !s) state_d = START;
            START:  if (vote_done) state_d = maj ? IDLE : DATA;
            DATA:   if (vote_done && bit_idx == BW'(DATA_WIDTH - 1))
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (vote_done) state_d = STOP;
            STOP:   if (vote_done && stop_idx == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        push    = 1'b1;
                    end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and frame datapath; the counter free-runs across bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            v0       <= 1'b1;
            v1       <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            armed    <= 1'b1;
        end else begin
            if (state == IDLE)                   cnt <= '0;
            else if (cnt == CW'(CLK_PER_BIT - 1)) cnt <= '0;
            else                                 cnt <= cnt + CW'(1);

            if (cnt == CW'(MID - 1)) v0 <= s;
            if (cnt == CW'(MID))     v1 <= s;

            if (state == START) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_err  <= 1'b0;
                frm_err  <= 1'b0;
            end
            if (state == DATA && vote_done) begin
                shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end
            if (state == PARITY && vote_done) par_err <= par_bad;
            if (state == STOP && vote_done) begin
                frm_err  <= push_ferr;
                stop_idx <= ~stop_idx;
            end

            // A low stop bit may be a break: wait for the line to go high first.
            if (s)                       armed <= 1'b1;
            else if (push && push_ferr)  armed <= 1'b0;
        end
    end

    assign full   = (count == NW'(FIFO_DEPTH));
    assign do_pop = rx_valid && rx_ready;
    assign accept = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {push_ferr, par_err, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (accept && !do_pop)      count <= count + NW'(1);
            else if (!accept && do_pop) count <= count - NW'(1);
            if (push && full && !do_pop) overrun <= 1'b1;
            else if (overrun_clr)        overrun <= 1'b0;
        end
    end

    assign head          = mem[rd_ptr];
    assign rx_valid      = (count != '0);
    assign rx_data       = rx_valid ? head[DATA_WIDTH-1:0] : '0;
    assign rx_parity_err = rx_valid & head[DATA_WIDTH];
    assign rx_frame_err  = rx_valid & head[DATA_WIDTH+1];
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the team's UART receiver. Adds selectable parity mode (none/even/odd), 1 or 2 stop bits, 3-sample majority voting, false-start rejection, framing-error detection and a show-ahead receive FIFO with valid/ready handshake and a sticky overrun flag. Sits between the serial pin and the control FSM; the consumer pops bytes at its own pace.

Parameters:
CLK_PER_BIT, 50, clk cycles per bit; must be >= 4.
DATA_WIDTH, 8, data bits per frame, 5..9.
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 2, 1 or 2.
FIFO_DEPTH, 4, entries; must be a power of 2 and >= 2.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
rx_in  in  1  asynchronous serial input; idle high.
rx_data  out  DATA_WIDTH  FIFO head data.
rx_parity_err  out  1  parity error flag of the head entry.
rx_frame_err  out  1  framing error flag of the head entry.
rx_valid  out  1  FIFO non-empty.
rx_ready  in  1  consumer accepts the head entry.
overrun  out  1  sticky: a completed frame was dropped because the FIFO was full.
overrun_clr  in  1  clears overrun.
busy  out  1  receiver not in IDLE.

Behaviour:
- Input sync: 2-flop synchroniser, both flops reset to 1. Everything below uses the synced value s.
- Sampling: bit centre offset MID = (CLK_PER_BIT-1)/2 cycles after the falling edge is detected. Each bit value is the majority of s at centre-1, centre and centre+1. The same counter restarts every CLK_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: s == 0 -> START, counter = 0.
  - START: at centre+1, majority 1 -> IDLE (false start, no push, no flags); majority 0 -> DATA.
  - DATA: DATA_WIDTH bits, LSB first. After the last bit -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: even mode: error if XOR(data, parity bit) = 1. Odd mode: error if XOR = 0.
  - STOP: STOP_BITS bits. frame_err = 1 if any stop bit votes 0.
    - At the cycle the last stop bit's vote completes (centre+1): push the entry and go to IDLE that same cycle. This allows back-to-back frames.
    - With a 0 stop bit, IDLE re-arms only once s == 1 is seen, so a break is not taken as a new start.
- FIFO:
  - Entry = {frame_err, parity_err, data}. Show-ahead: head visible on rx_data/rx_*_err whenever rx_valid = 1.
  - Pop occurs when rx_valid && rx_ready.
  - Push latency: rx_valid rises the cycle after the push cycle.
  - Push when full without a same-cycle pop: entry dropped, overrun <= 1. Push when full with a same-cycle pop: accepted, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
  - overrun_clr and a new overrun in the same cycle: overrun stays 1 (set wins).
- Reset values: rx_data 0, both error outputs 0, rx_valid 0, overrun 0, busy 0, FSM IDLE, FIFO empty.
- Reset mid-frame: the partial frame is discarded, no push occurs, and FIFO contents are lost.

Test Plan:
- CLK_PER_BIT=16, even parity, 2 stop bits. Send 0xA5 with parity 0, stops 11, rx_ready=1 -> one pop: rx_data=0xA5, parity_err=0, frame_err=0, overrun=0.
- Same frame with parity bit 1 -> rx_data=0xA5, parity_err=1. Then send 0x3C with the second stop bit 0 -> rx_data=0x3C, frame_err=1, parity_err=0.
- rx_in low for 3 cycles, then high -> busy pulses, returns to IDLE, rx_valid stays 0.
- rx_ready=0, send 0x01..0x05 back-to-back with depth 4 -> overrun=1 after the 5th frame. Raise rx_ready -> pops 0x01,0x02,0x03,0x04, then rx_valid=0. Pulse overrun_clr -> overrun=0.
- Single-cycle glitch inside a data bit at centre (one of three samples flipped) -> byte still received correctly, e.g. 0xFF.
- Assert rst during DATA of a frame, then send 0x5A cleanly -> only 0x5A is popped, no error flags.
